// File: rtl/dac_capture_pkg.sv
// rtl/dac_capture_pkg.sv - shared types and constants for the DAC sample capture block
package dac_capture_pkg;

  // Capture FSM: IDLE while the active source is disabled, ARMED while waiting
  // for the selected sample, CAPTURED once the frame's sample is held.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } cap_state_e;

  // Offset-binary zero: the DAC rests here whenever no source is selected.
  localparam logic [15:0] MIDSCALE = 16'h8000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear, where an increment beats a clear
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  // A clear coinciding with an increment leaves exactly one event recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dac_sample_capture.sv
// rtl/dac_sample_capture.sv - picks one amplifier sample per frame and holds it for the DAC
module dac_sample_capture #(
  parameter int STREAM_W = 5,
  parameter int CHAN_W   = 6,
  parameter int MISS_W   = 8
) (
  input  logic                dataclk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [STREAM_W-1:0] sample_stream,
  input  logic [CHAN_W-1:0]   sample_channel,
  input  logic [15:0]         sample_data,
  input  logic                frame_end,
  input  logic [STREAM_W-1:0] sel_stream,
  input  logic [CHAN_W-1:0]   sel_channel,
  input  logic                sel_en,
  input  logic                miss_clear,
  output logic [15:0]         DAC_input,
  output logic                DAC_input_valid,
  output logic                capture_miss,
  output logic [MISS_W-1:0]   miss_count,
  output logic                dup_seen
);

  import dac_capture_pkg::*;

  // Selection actually in force for the current frame.
  logic [STREAM_W-1:0] act_stream;
  logic [CHAN_W-1:0]   act_channel;
  logic                act_en;

  cap_state_e state, next_state;
  logic [15:0] capture_reg;
  logic        match;

  // Per-cycle decisions from the FSM.
  logic load_capture;
  logic commit_direct;
  logic commit_capture;
  logic commit_mid;
  logic miss_event;
  logic dup_event;

  assign match = sample_valid &&
                 (sample_stream == act_stream) &&
                 (sample_channel == act_channel);

  // Software selection only takes effect at a frame boundary.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      act_stream  <= '0;
      act_channel <= '0;
      act_en      <= 1'b0;
    end else if (frame_end) begin
      act_stream  <= sel_stream;
      act_channel <= sel_channel;
      act_en      <= sel_en;
    end
  end

  // FSM state register.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and datapath controls; a match on the frame_end cycle belongs
  // to the frame that is ending.
  always_comb begin
    next_state     = state;
    load_capture   = 1'b0;
    commit_direct  = 1'b0;
    commit_capture = 1'b0;
    commit_mid     = 1'b0;
    miss_event     = 1'b0;
    dup_event      = 1'b0;

    case (state)
      IDLE: begin
        if (frame_end) begin
          commit_mid = 1'b1;
        end
      end
      ARMED: begin
        if (frame_end) begin
          if (match) begin
            commit_direct = 1'b1;
          end else begin
            miss_event = 1'b1;
          end
        end else if (match) begin
          load_capture = 1'b1;
          next_state   = CAPTURED;
        end
      end
      CAPTURED: begin
        if (match) begin
          dup_event = 1'b1;
        end
        if (frame_end) begin
          commit_capture = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    // Every frame boundary re-arms from the freshly shadowed enable.
    if (frame_end) begin
      next_state = sel_en ? ARMED : IDLE;
    end

    // act_en is folded into the state itself; it only matters as reset state.
    if (!act_en && (state != IDLE) && !frame_end) begin
      next_state = state;
    end
  end

  // Capture register holds the first matching sample of the frame.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      capture_reg <= '0;
    end else if (load_capture) begin
      capture_reg <= sample_data;
    end
  end

  // DAC output register and its one-cycle commit strobe.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      DAC_input       <= MIDSCALE;
      DAC_input_valid <= 1'b0;
    end else begin
      DAC_input_valid <= commit_direct | commit_capture;
      if (commit_direct) begin
        DAC_input <= sample_data;
      end else if (commit_capture) begin
        DAC_input <= capture_reg;
      end else if (commit_mid) begin
        DAC_input <= MIDSCALE;
      end
    end
  end

  // Sticky status flags; a new event beats a simultaneous clear.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      capture_miss <= 1'b0;
      dup_seen     <= 1'b0;
    end else begin
      if (miss_event) begin
        capture_miss <= 1'b1;
      end else if (miss_clear) begin
        capture_miss <= 1'b0;
      end
      if (dup_event) begin
        dup_seen <= 1'b1;
      end else if (miss_clear) begin
        dup_seen <= 1'b0;
      end
    end
  end

  sat_counter #(
    .WIDTH (MISS_W)
  ) u_miss_counter (
    .clk   (dataclk),
    .rst_n (reset),
    .inc   (miss_event),
    .clr   (miss_clear),
    .count (miss_count)
  );

endmodule

// File: tb/tb_dac_sample_capture.sv
// tb/tb_dac_sample_capture.sv - directed vector bench for dac_sample_capture
module tb_dac_sample_capture;

  logic        dataclk;
  logic        reset;
  logic        sample_valid;
  logic [4:0]  sample_stream;
  logic [5:0]  sample_channel;
  logic [15:0] sample_data;
  logic        frame_end;
  logic [4:0]  sel_stream;
  logic [5:0]  sel_channel;
  logic        sel_en;
  logic        miss_clear;
  logic [15:0] DAC_input;
  logic        DAC_input_valid;
  logic        capture_miss;
  logic [7:0]  miss_count;
  logic        dup_seen;

  int checks;
  int failures;

  dac_sample_capture #(
    .STREAM_W (5),
    .CHAN_W   (6),
    .MISS_W   (8)
  ) dut (
    .dataclk         (dataclk),
    .reset           (reset),
    .sample_valid    (sample_valid),
    .sample_stream   (sample_stream),
    .sample_channel  (sample_channel),
    .sample_data     (sample_data),
    .frame_end       (frame_end),
    .sel_stream      (sel_stream),
    .sel_channel     (sel_channel),
    .sel_en          (sel_en),
    .miss_clear      (miss_clear),
    .DAC_input       (DAC_input),
    .DAC_input_valid (DAC_input_valid),
    .capture_miss    (capture_miss),
    .miss_count      (miss_count),
    .dup_seen        (dup_seen)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;

  typedef struct {
    logic        sv;
    logic [4:0]  st;
    logic [5:0]  ch;
    logic [15:0] d;
    logic        fe;
    logic [4:0]  sst;
    logic [5:0]  sch;
    logic        sen;
    logic        clr;
    logic [15:0] e_dac;
    logic        e_dv;
    logic        e_miss;
    logic [7:0]  e_cnt;
    logic        e_dup;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic sv, input logic [4:0] st, input logic [5:0] ch,
                     input logic [15:0] d, input logic fe, input logic [4:0] sst,
                     input logic [5:0] sch, input logic sen, input logic clr,
                     input logic [15:0] e_dac, input logic e_dv, input logic e_miss,
                     input logic [7:0] e_cnt, input logic e_dup);
    vec_t v;
    v.sv = sv; v.st = st; v.ch = ch; v.d = d; v.fe = fe;
    v.sst = sst; v.sch = sch; v.sen = sen; v.clr = clr;
    v.e_dac = e_dac; v.e_dv = e_dv; v.e_miss = e_miss; v.e_cnt = e_cnt; v.e_dup = e_dup;
    tbl.push_back(v);
  endtask

  task automatic check_out(input string nm, input logic [15:0] e_dac, input logic e_dv,
                           input logic e_miss, input logic [7:0] e_cnt, input logic e_dup);
    logic [26:0] got;
    logic [26:0] exp;
    got = {DAC_input, DAC_input_valid, capture_miss, miss_count, dup_seen};
    exp = {e_dac, e_dv, e_miss, e_cnt, e_dup};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got dac=%h valid=%b miss=%b cnt=%0d dup=%b, expected dac=%h valid=%b miss=%b cnt=%0d dup=%b",
               nm, DAC_input, DAC_input_valid, capture_miss, miss_count, dup_seen,
               e_dac, e_dv, e_miss, e_cnt, e_dup);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge dataclk);
    sample_valid   = v.sv;
    sample_stream  = v.st;
    sample_channel = v.ch;
    sample_data    = v.d;
    frame_end      = v.fe;
    sel_stream     = v.sst;
    sel_channel    = v.sch;
    sel_en         = v.sen;
    miss_clear     = v.clr;
    @(posedge dataclk);
    #1;
    check_out(nm, v.e_dac, v.e_dv, v.e_miss, v.e_cnt, v.e_dup);
  endtask

  initial begin
    vec_t h;
    checks   = 0;
    failures = 0;

    reset          = 1'b0;
    sample_valid   = 1'b0;
    sample_stream  = '0;
    sample_channel = '0;
    sample_data    = '0;
    frame_end      = 1'b0;
    sel_stream     = '0;
    sel_channel    = '0;
    sel_en         = 1'b0;
    miss_clear     = 1'b0;

    //   sv st  ch  data      fe sst sch sen clr  dac       dv miss cnt dup
    // basic capture
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h8000, 0, 0, 0, 0);
    add(1, 3, 17, 16'h9ABC, 0, 3, 17, 1, 0, 16'h8000, 0, 0, 0, 0);
    add(1, 3, 18, 16'hFFFF, 0, 3, 17, 1, 0, 16'h8000, 0, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h9ABC, 1, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 0, 3, 17, 1, 0, 16'h9ABC, 0, 0, 0, 0);
    // three missed frames, then clear
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h9ABC, 0, 1, 1, 0);
    add(1, 4, 17, 16'h5A5A, 0, 3, 17, 1, 0, 16'h9ABC, 0, 1, 1, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h9ABC, 0, 1, 2, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h9ABC, 0, 1, 3, 0);
    add(0, 0,  0, 16'h0000, 0, 3, 17, 1, 1, 16'h9ABC, 0, 0, 0, 0);
    // duplicate within one frame
    add(1, 3, 17, 16'h1111, 0, 3, 17, 1, 0, 16'h9ABC, 0, 0, 0, 0);
    add(1, 3, 17, 16'h2222, 0, 3, 17, 1, 0, 16'h9ABC, 0, 0, 0, 1);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h1111, 1, 0, 0, 1);
    add(0, 0,  0, 16'h0000, 0, 3, 17, 1, 1, 16'h1111, 0, 0, 0, 0);
    // match on frame_end, then next frame misses (proves ARMED, not CAPTURED)
    add(1, 3, 17, 16'h1234, 1, 3, 17, 1, 0, 16'h1234, 1, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h1234, 0, 1, 1, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h1234, 0, 1, 2, 0);
    // miss and clear together: set wins, count restarts at 1
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 1, 16'h1234, 0, 1, 1, 0);
    add(0, 0,  0, 16'h0000, 0, 3, 17, 1, 1, 16'h1234, 0, 0, 0, 0);
    // disable: last capture commits, then midscale with no strobe
    add(1, 3, 17, 16'h5555, 0, 3, 17, 1, 0, 16'h1234, 0, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 0, 0, 16'h5555, 1, 0, 0, 0);
    add(1, 3, 17, 16'h7777, 0, 3, 17, 0, 0, 16'h5555, 0, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 0, 0, 16'h8000, 0, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 1, 3, 17, 1, 0, 16'h8000, 0, 0, 0, 0);
    // selection change mid-frame keeps the old source until frame_end
    add(1, 3, 17, 16'h4321, 0, 5,  9, 1, 0, 16'h8000, 0, 0, 0, 0);
    add(1, 5,  9, 16'hAAAA, 0, 5,  9, 1, 0, 16'h8000, 0, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 1, 5,  9, 1, 0, 16'h4321, 1, 0, 0, 0);
    add(1, 3, 17, 16'hBBBB, 0, 5,  9, 1, 0, 16'h4321, 0, 0, 0, 0);
    add(1, 5,  9, 16'hCCCC, 0, 5,  9, 1, 0, 16'h4321, 0, 0, 0, 0);
    add(0, 0,  0, 16'h0000, 1, 5,  9, 1, 0, 16'hCCCC, 1, 0, 0, 0);
    add(1, 5,  9, 16'hDDDD, 0, 5,  9, 1, 0, 16'hCCCC, 0, 0, 0, 0);

    repeat (3) @(posedge dataclk);
    #1;
    check_out("reset_state", 16'h8000, 0, 0, 0, 0);
    @(negedge dataclk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-frame drops the held DDDD capture.
    @(negedge dataclk);
    sample_valid = 1'b0;
    frame_end    = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_out("async_reset", 16'h8000, 0, 0, 0, 0);
    @(negedge dataclk);
    reset = 1'b1;
    h = '{sv:0, st:0, ch:0, d:16'h0, fe:1, sst:5, sch:9, sen:1, clr:0,
          e_dac:16'h8000, e_dv:0, e_miss:0, e_cnt:0, e_dup:0};
    run_vec(h, "post_reset_idle_frame");
    h.e_miss = 1; h.e_cnt = 1;
    run_vec(h, "post_reset_armed_miss");

    // Saturation over 300 missed frames.
    h = '{sv:0, st:0, ch:0, d:16'h0, fe:0, sst:5, sch:9, sen:1, clr:1,
          e_dac:16'h8000, e_dv:0, e_miss:0, e_cnt:0, e_dup:0};
    run_vec(h, "sat_clear");
    for (int i = 0; i < 300; i++) begin
      h.fe = 1; h.clr = 0; h.e_miss = 1;
      h.e_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      run_vec(h, $sformatf("sat_frame%0d", i + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
